// File: rtl/muldiv_ctrl.sv
// Sequencer for the EX-stage multiply/divide units: accepts one MD request,
// stalls EX until the result is captured, then issues one HI/LO write.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hold,
    input  logic        flush,
    output logic        stallreq,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_BUSY, DONE} state_t;

    state_t        state;
    logic [2:0]    op_r;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic [CW-1:0] cnt;
    logic [DW-1:0] hi_r;
    logic [DW-1:0] lo_r;

    logic md_req;
    logic req_is_mul;
    logic b_zero;

    assign md_req     = req_valid && (req_op >= OP_MULT) && (req_op <= OP_DIVU);
    assign req_is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
    assign b_zero     = (b_r == '0);

    // State and datapath registers; flush only redirects the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            cnt   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (md_req) begin
                        op_r <= req_op;
                        a_r  <= src_a;
                        b_r  <= src_b;
                        if (req_is_mul) begin
                            cnt   <= CNT_INIT;
                            state <= MUL_WAIT;
                        end else begin
                            state <= DIV_BUSY;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (cnt == '0) begin
                        hi_r  <= mul_result[63:32];
                        lo_r  <= mul_result[31:0];
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DIV_BUSY: begin
                    // Divide by zero bypasses the divider entirely
                    if (b_zero) begin
                        hi_r  <= a_r;
                        lo_r  <= '1;
                        state <= DONE;
                    end else if (div_ready) begin
                        hi_r  <= div_result[63:32];
                        lo_r  <= div_result[31:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!hold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand buses are decoded from registered state only
    assign mul_signed = (state == MUL_WAIT) && (op_r == OP_MULT);
    assign mul_ina    = (state == MUL_WAIT) ? a_r : '0;
    assign mul_inb    = (state == MUL_WAIT) ? b_r : '0;
    assign div_signed = (state == DIV_BUSY) && (op_r == OP_DIV);
    assign div_opa    = (state == DIV_BUSY) ? a_r : '0;
    assign div_opb    = (state == DIV_BUSY) ? b_r : '0;
    assign hi_wdata   = hi_r;
    assign lo_wdata   = lo_r;

    // Handshake strobes react in-cycle to EX, divider, flush and reset
    assign stallreq  = !rst && !flush &&
                       (((state == IDLE) && md_req) || (state == MUL_WAIT) || (state == DIV_BUSY));
    assign div_start = !rst && !flush && (state == DIV_BUSY) && !div_ready && !b_zero;
    assign div_annul = !rst && flush && (state == DIV_BUSY);
    assign hilo_we   = !rst && !flush && (state == DONE) && !hold;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: table-driven operations with a write
// scoreboard plus hand sequences for flush, hold, reset and stale ready.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hold;
    logic        flush;
    logic        stallreq;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_annul;
    logic        div_ready;
    logic [63:0] div_result;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    muldiv_ctrl #(.MUL_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .src_a(src_a), .src_b(src_b), .hold(hold), .flush(flush),
        .stallreq(stallreq), .mul_signed(mul_signed), .mul_ina(mul_ina),
        .mul_inb(mul_inb), .mul_result(mul_result), .div_start(div_start),
        .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
        .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stall = 0;
    int n_start = 0;
    int n_annul = 0;
    int n_we    = 0;
    logic [63:0] exp_q[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Unit models: single-cycle-valid multiplier, divider with programmable delay
    function automatic logic [63:0] mul_calc(logic s, logic [31:0] a, logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = s ? {{32{a[31]}}, a} : {32'b0, a};
        xb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    function automatic logic [63:0] div_calc(logic s, logic [31:0] a, logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign mul_result = mul_calc(mul_signed, mul_ina, mul_inb);

    int   div_delay = 1;
    int   dcnt = 0;
    logic mdl_ready = 1'b0;
    logic inj_ready = 1'b0;
    assign div_ready = mdl_ready | inj_ready;

    always @(posedge clk) begin
        if (div_start && !mdl_ready) begin
            if (dcnt + 1 >= div_delay) begin
                mdl_ready  <= 1'b1;
                div_result <= div_calc(div_signed, div_opa, div_opb);
                dcnt       <= 0;
            end else begin
                mdl_ready <= 1'b0;
                dcnt      <= dcnt + 1;
            end
        end else begin
            mdl_ready <= 1'b0;
            dcnt      <= 0;
        end
    end

    // Monitor: counts strobes and scores every HI/LO write
    always @(negedge clk) begin
        if (stallreq)  n_stall++;
        if (div_start) n_start++;
        if (div_annul) n_annul++;
        if (hilo_we) begin
            n_we++;
            if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
            else check("hilo_data", {hi_wdata, lo_wdata}, exp_q.pop_front());
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          delay;
        int          stall;
        int          starts;
        logic        sgn;
    } vec_t;

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the write
    task automatic run_op(input vec_t v, input string name);
        int we0;
        int c;
        div_delay = v.delay;
        req_valid = 1'b1; req_op = v.op; src_a = v.a; src_b = v.b;
        exp_q.push_back({v.hi, v.lo});
        n_stall = 0; n_start = 0; we0 = n_we;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
        @(negedge clk);
        if (v.op == 3'd1 || v.op == 3'd2) begin
            check({name, "_mul_signed"}, 64'(mul_signed), 64'(v.sgn));
            check({name, "_mul_ops"}, {mul_ina, mul_inb}, {v.a, v.b});
            check({name, "_div_ops_idle"}, {div_opa, div_opb}, 64'd0);
        end else begin
            check({name, "_div_signed"}, 64'(div_signed), 64'(v.sgn));
            check({name, "_div_ops"}, {div_opa, div_opb}, {v.a, v.b});
            check({name, "_mul_ops_idle"}, {mul_ina, mul_inb}, 64'd0);
        end
        c = 0;
        while (n_we == we0 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check({name, "_done_timeout"}, 64'(n_we == we0), 64'd0);
        check({name, "_stall_cycles"}, 64'(n_stall), 64'(v.stall));
        check({name, "_start_cycles"}, 64'(n_start), 64'(v.starts));
    endtask

    vec_t vecs[8];
    int we_snap;

    initial begin
        vecs[0] = '{3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 0,  2,  0,  1'b1};
        vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 0,  2,  0,  1'b0};
        vecs[2] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0,  2,  0,  1'b1};
        vecs[3] = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        33, 35, 33, 1'b0};
        vecs[4] = '{3'd3, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 32'hFFFF_FFFA, 5,  7,  5,  1'b1};
        vecs[5] = '{3'd3, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 0,  2,  0,  1'b1};
        vecs[6] = '{3'd4, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 0,  2,  0,  1'b0};
        vecs[7] = '{3'd2, 32'd4,         32'd4,        32'd0,         32'd16,        0,  2,  0,  1'b0};

        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; src_a = '0; src_b = '0;
        hold = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {60'd0, stallreq, hilo_we, div_start, div_annul}, 64'd0);
        check("reset_data", {hi_wdata, lo_wdata}, 64'd0);
        check("reset_ops", {mul_ina, div_opa}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back table operations
        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // DONE held by downstream stall: no write until hold drops
        hold = 1'b1; req_valid = 1'b1; req_op = 3'd2; src_a = 32'd4; src_b = 32'd4;
        exp_q.push_back({32'd0, 32'd16});
        we_snap = n_we;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_no_write", i), 64'(hilo_we), 64'd0);
            check($sformatf("hold%0d_no_stall", i), 64'(stallreq), 64'd0);
            check($sformatf("hold%0d_lo", i), 64'(lo_wdata), 64'd16);
            @(posedge clk); #1;
        end
        hold = 1'b0;
        @(negedge clk);
        check("hold_release_write", 64'(hilo_we), 64'd1);
        @(negedge clk);
        check("hold_after_write", 64'(hilo_we), 64'd0);
        check("hold_single_pulse", 64'(n_we - we_snap), 64'd1);
        @(posedge clk); #1;

        // Flush during DIV_BUSY at T5
        div_delay = 40; n_annul = 0; we_snap = n_we;
        req_valid = 1'b1; req_op = 3'd3; src_a = 32'd20; src_b = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
        repeat (4) @(posedge clk);
        #1; flush = 1'b1;
        @(negedge clk);
        check("flush_annul", 64'(div_annul), 64'd1);
        check("flush_strobes", {61'd0, div_start, stallreq, hilo_we}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle", {31'd0, div_annul, stallreq, div_opa}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_annul_count", 64'(n_annul), 64'd1);
        check("flush_no_write", 64'(n_we - we_snap), 64'd0);

        // Flush coinciding with an IDLE request discards it
        req_valid = 1'b1; req_op = 3'd1; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
        @(negedge clk);
        check("flush_req_stall", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0; flush = 1'b0;
        @(negedge clk);
        check("flush_req_dropped", {31'd0, stallreq, mul_ina}, 64'd0);
        @(posedge clk); #1;
        run_op('{3'd2, 32'd2, 32'd3, 32'd0, 32'd6, 0, 2, 0, 1'b0}, "post_flush");

        // Reset mid-DIV_BUSY, then a stale divider ready
        div_delay = 20; we_snap = n_we;
        req_valid = 1'b1; req_op = 3'd4; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
        check("rst_gates_stall", {62'd0, stallreq, div_start}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_strobes", {58'd0, stallreq, hilo_we, div_start, div_annul, mul_signed, div_signed}, 64'd0);
        check("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
        check("rst_ops", {mul_ina, mul_inb}, 64'd0);
        check("rst_div_ops", {div_opa, div_opb}, 64'd0);
        @(posedge clk); #1;
        inj_ready = 1'b1;
        @(posedge clk); #1;
        inj_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stale_ready_no_write", 64'(n_we - we_snap), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
